// File: rtl/fpg8_pkg.sv
// Shared types and encodings for the fpg8 hardwired control sequencer:
// FSM states, opcodes, ALU codes, GPR select codes and the packed control word.
package fpg8_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_F0   = 3'd1,
    ST_F1   = 3'd2,
    ST_F2   = 3'd3,
    ST_E0   = 3'd4,
    ST_E1   = 3'd5,
    ST_E2   = 3'd6,
    ST_HALT = 3'd7
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LOAD  = 4'd1;
  localparam logic [3:0] OP_STORE = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_MOV   = 4'd7;
  localparam logic [3:0] OP_HALT  = 4'd15;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;
  localparam logic [2:0] ALU_INC  = 3'd5;

  localparam logic [2:0] SEL_RD1 = 3'd0;
  localparam logic [2:0] SEL_RD2 = 3'd1;
  localparam logic [2:0] SEL_RS1 = 3'd2;
  localparam logic [2:0] SEL_RS2 = 3'd3;

  // done/halt_req/bad_op are sequencing hints for the top, not datapath strobes.
  typedef struct packed {
    logic [2:0] alu;
    logic [2:0] sel;
    logic       gpr_in;
    logic       gpr_out;
    logic       ir_in;
    logic       mar_in;
    logic       mdr_in;
    logic       mdr_out;
    logic       y_in;
    logic       z_in;
    logic       z_out;
    logic       ram_rd;
    logic       ram_wr;
    logic       done;
    logic       halt_req;
    logic       bad_op;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  function automatic logic [2:0] alu_of(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational decode of (state, opcode, advance) into the fpg8 control word.
// Everything is forced to zero unless advance is high, so stalls never strobe.
module control_decoder
  import fpg8_pkg::*;
#(
  parameter logic [2:0] PC_SEL = 3'd4
) (
  input  logic [2:0]        state,
  input  logic [3:0]        opcode,
  input  logic              advance,
  output logic [CTRL_W-1:0] ctrl
);

  state_t st;
  ctrl_t  c;

  assign st   = state_t'(state);
  assign ctrl = c;

  always_comb begin
    c = '0;
    if (advance) begin
      case (st)
        ST_F0: begin
          c.gpr_out = 1'b1;
          c.sel     = PC_SEL;
          c.mar_in  = 1'b1;
          c.alu     = ALU_INC;
          c.z_in    = 1'b1;
        end
        ST_F1: begin
          c.ram_rd = 1'b1;
          c.z_out  = 1'b1;
          c.gpr_in = 1'b1;
          c.sel    = PC_SEL;
        end
        ST_F2: begin
          c.mdr_out = 1'b1;
          c.ir_in   = 1'b1;
        end
        ST_E0: begin
          case (opcode)
            OP_LOAD, OP_STORE: begin
              c.gpr_out = 1'b1;
              c.sel     = SEL_RS1;
              c.mar_in  = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              c.gpr_out = 1'b1;
              c.sel     = SEL_RS1;
              c.y_in    = 1'b1;
            end
            OP_MOV: begin
              c.gpr_out = 1'b1;
              c.sel     = SEL_RS1;
              c.alu     = ALU_PASS;
              c.z_in    = 1'b1;
            end
            OP_HALT: c.halt_req = 1'b1;
            OP_NOP:  c.done = 1'b1;
            default: begin
              c.done   = 1'b1;
              c.bad_op = 1'b1;
            end
          endcase
        end
        ST_E1: begin
          case (opcode)
            OP_LOAD: c.ram_rd = 1'b1;
            OP_STORE: begin
              c.gpr_out = 1'b1;
              c.sel     = SEL_RD1;
              c.mdr_in  = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              c.gpr_out = 1'b1;
              c.sel     = SEL_RS2;
              c.alu     = alu_of(opcode);
              c.z_in    = 1'b1;
            end
            OP_MOV: begin
              c.z_out  = 1'b1;
              c.gpr_in = 1'b1;
              c.sel    = SEL_RD1;
              c.done   = 1'b1;
            end
            default: c.done = 1'b1;
          endcase
        end
        ST_E2: begin
          case (opcode)
            OP_LOAD: begin
              c.mdr_out = 1'b1;
              c.gpr_in  = 1'b1;
              c.sel     = SEL_RD1;
            end
            OP_STORE: c.ram_wr = 1'b1;
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              c.z_out  = 1'b1;
              c.gpr_in = 1'b1;
              c.sel    = SEL_RD1;
            end
            default: ;
          endcase
          c.done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// fpg8 hardwired microsequencer: state register, retired-instruction counter
// and sticky halted/illegal flags around the combinational control decoder.
//
//   state | meaning
//   IDLE  | out of reset, no strobes
//   F0    | PC -> MAR, Z = PC + 1
//   F1    | RAM read, Z -> PC
//   F2    | MDR -> IR
//   E0    | execute step 0 (NOP/illegal retire here, HALT leaves here)
//   E1    | execute step 1 (MOV retires here)
//   E2    | execute step 2 (LOAD/STORE/ALU retire here)
//   HALT  | stopped until reset, no strobes
module control_sequencer
  import fpg8_pkg::*;
#(
  parameter logic [2:0] PC_SEL = 3'd4,
  parameter int         CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  input  logic [3:0]       opcode,
  output logic [2:0]       ALU_control,
  output logic             GPR_in,
  output logic             GPR_out,
  output logic [2:0]       GPR_select,
  output logic             IR_in,
  output logic             MAR_in,
  output logic             MDR_in,
  output logic             MDR_out,
  output logic             Y_in,
  output logic             Z_in,
  output logic             Z_out,
  output logic             RAM_enable_read,
  output logic             RAM_enable_write,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count,
  output logic             halted,
  output logic             illegal
);

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] ctrl_bits;
  ctrl_t             ctrl;
  logic              step;

  // Gating with reset keeps strobes low in the same cycle reset is asserted.
  assign step = advance & reset;

  control_decoder #(.PC_SEL(PC_SEL)) u_decoder (
    .state   (state_q),
    .opcode  (opcode),
    .advance (step),
    .ctrl    (ctrl_bits)
  );

  assign ctrl = ctrl_t'(ctrl_bits);

  assign ALU_control      = ctrl.alu;
  assign GPR_select       = ctrl.sel;
  assign GPR_in           = ctrl.gpr_in;
  assign GPR_out          = ctrl.gpr_out;
  assign IR_in            = ctrl.ir_in;
  assign MAR_in           = ctrl.mar_in;
  assign MDR_in           = ctrl.mdr_in;
  assign MDR_out          = ctrl.mdr_out;
  assign Y_in             = ctrl.y_in;
  assign Z_in             = ctrl.z_in;
  assign Z_out            = ctrl.z_out;
  assign RAM_enable_read  = ctrl.ram_rd;
  assign RAM_enable_write = ctrl.ram_wr;
  assign instr_done       = ctrl.done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      instr_count <= '0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ctrl.done)     instr_count <= instr_count + CNT_W'(1);
      if (ctrl.halt_req) halted      <= 1'b1;
      if (ctrl.bad_op)   illegal     <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (advance) begin
      case (state_q)
        ST_IDLE: state_d = ST_F0;
        ST_F0:   state_d = ST_F1;
        ST_F1:   state_d = ST_F2;
        ST_F2:   state_d = ST_E0;
        ST_E0: begin
          if (ctrl.halt_req)  state_d = ST_HALT;
          else if (ctrl.done) state_d = ST_F0;
          else                state_d = ST_E1;
        end
        ST_E1:   state_d = ctrl.done ? ST_F0 : ST_E2;
        ST_E2:   state_d = ST_F0;
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch/execute strobe patterns, stall,
// illegal opcode, halt, reset mid-instruction, and counter wrap on a narrow instance.
module tb_control_sequencer;
  import fpg8_pkg::*;

  localparam logic [11:0] GIN  = 12'h800;
  localparam logic [11:0] GOUT = 12'h400;
  localparam logic [11:0] IRI  = 12'h200;
  localparam logic [11:0] MARI = 12'h100;
  localparam logic [11:0] MDRI = 12'h080;
  localparam logic [11:0] MDRO = 12'h040;
  localparam logic [11:0] YI   = 12'h020;
  localparam logic [11:0] ZI   = 12'h010;
  localparam logic [11:0] ZO   = 12'h008;
  localparam logic [11:0] RE   = 12'h004;
  localparam logic [11:0] WE   = 12'h002;
  localparam logic [11:0] DN   = 12'h001;

  localparam logic [17:0] F0_CW = {3'd5, 3'd4, GOUT | MARI | ZI};
  localparam logic [17:0] F1_CW = {3'd0, 3'd4, RE | ZO | GIN};
  localparam logic [17:0] F2_CW = {3'd0, 3'd0, MDRO | IRI};

  logic clk;
  logic reset, advance;
  logic [3:0] opcode;
  logic [2:0] alu, sel;
  logic gin, gout, iri, mari, mdri, mdro, yi, zi, zo, re, we, done;
  logic [15:0] count;
  logic halted, illegal;

  logic reset_b, advance_b;
  logic [3:0] opcode_b;
  logic [2:0] alu_b, sel_b;
  logic gin_b, gout_b, iri_b, mari_b, mdri_b, mdro_b, yi_b, zi_b, zo_b, re_b, we_b, done_b;
  logic [3:0] count_b;
  logic halted_b, illegal_b;

  logic [17:0] cw;
  logic [17:0] acc;
  int checks = 0;
  int errors = 0;

  assign cw = {alu, sel, gin, gout, iri, mari, mdri, mdro, yi, zi, zo, re, we, done};

  control_sequencer dut (
    .clk(clk), .reset(reset), .advance(advance), .opcode(opcode),
    .ALU_control(alu), .GPR_in(gin), .GPR_out(gout), .GPR_select(sel),
    .IR_in(iri), .MAR_in(mari), .MDR_in(mdri), .MDR_out(mdro),
    .Y_in(yi), .Z_in(zi), .Z_out(zo),
    .RAM_enable_read(re), .RAM_enable_write(we),
    .instr_done(done), .instr_count(count), .halted(halted), .illegal(illegal)
  );

  control_sequencer #(.CNT_W(4)) dut_b (
    .clk(clk), .reset(reset_b), .advance(advance_b), .opcode(opcode_b),
    .ALU_control(alu_b), .GPR_in(gin_b), .GPR_out(gout_b), .GPR_select(sel_b),
    .IR_in(iri_b), .MAR_in(mari_b), .MDR_in(mdri_b), .MDR_out(mdro_b),
    .Y_in(yi_b), .Z_in(zi_b), .Z_out(zo_b),
    .RAM_enable_read(re_b), .RAM_enable_write(we_b),
    .instr_done(done_b), .instr_count(count_b), .halted(halted_b), .illegal(illegal_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] e(input logic [2:0] a, input logic [2:0] s, input logic [11:0] f);
    return {a, s, f};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the control word of the current state, then let one clock edge pass.
  task automatic cyc(input string tag, input logic [17:0] exp);
    #1 check(tag, 32'(cw), 32'(exp));
    @(negedge clk);
  endtask

  task automatic fetch(input string tag);
    cyc({tag, "_f0"}, F0_CW);
    cyc({tag, "_f1"}, F1_CW);
    cyc({tag, "_f2"}, F2_CW);
  endtask

  initial begin
    reset = 1'b0; advance = 1'b0; opcode = 4'd0;
    reset_b = 1'b0; advance_b = 1'b0; opcode_b = 4'd0;
    @(negedge clk);
    #1;
    check("rst_cw", 32'(cw), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("rst_count", 32'(count), 32'd0);
    check("rst_flags", {30'd0, halted, illegal}, 32'd0);

    // ADD
    reset = 1'b1; advance = 1'b1; opcode = OP_ADD;
    cyc("idle", 18'd0);
    fetch("add");
    cyc("add_e0", e(3'd0, 3'd2, GOUT | YI));
    cyc("add_e1", e(3'd1, 3'd3, GOUT | ZI));
    cyc("add_e2", e(3'd0, 3'd0, ZO | GIN | DN));
    #1 check("add_count", 32'(count), 32'd1);

    // LOAD with a 5-cycle stall in E1
    opcode = OP_LOAD;
    fetch("ld");
    cyc("ld_e0", e(3'd0, 3'd2, GOUT | MARI));
    advance = 1'b0;
    repeat (5) cyc("ld_stall", 18'd0);
    #1 check("ld_hold_state", 32'(dut.state_q), 32'(ST_E1));
    check("ld_hold_count", 32'(count), 32'd1);
    advance = 1'b1;
    cyc("ld_e1", e(3'd0, 3'd0, RE));
    cyc("ld_e2", e(3'd0, 3'd0, MDRO | GIN | DN));
    #1 check("ld_count", 32'(count), 32'd2);

    // Illegal opcode: NOP timing, sticky flag
    opcode = 4'd9;
    fetch("ill");
    cyc("ill_e0", e(3'd0, 3'd0, DN));
    #1 check("ill_flag", 32'(illegal), 32'd1);
    check("ill_count", 32'(count), 32'd3);

    // MOV: fetch continues after illegal
    opcode = OP_MOV;
    fetch("mov");
    cyc("mov_e0", e(3'd0, 3'd2, GOUT | ZI));
    cyc("mov_e1", e(3'd0, 3'd0, ZO | GIN | DN));
    #1 check("mov_count", 32'(count), 32'd4);
    check("mov_ill_sticky", 32'(illegal), 32'd1);

    // STORE, reset asserted in E2
    opcode = OP_STORE;
    fetch("st");
    cyc("st_e0", e(3'd0, 3'd2, GOUT | MARI));
    cyc("st_e1", e(3'd0, 3'd0, GOUT | MDRI));
    #1 check("st_e2", 32'(cw), 32'(e(3'd0, 3'd0, WE | DN)));
    reset = 1'b0;
    #1 check("st_rst_cw", 32'(cw), 32'd0);
    check("st_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("st_rst_count", 32'(count), 32'd0);
    check("st_rst_ill", 32'(illegal), 32'd0);
    @(negedge clk);
    #1 check("st_no_retire", 32'(count), 32'd0);

    // HALT
    reset = 1'b1; opcode = OP_HALT;
    cyc("h_idle", 18'd0);
    fetch("h");
    cyc("h_e0", 18'd0);
    #1 check("h_halted", 32'(halted), 32'd1);
    check("h_state", 32'(dut.state_q), 32'(ST_HALT));
    check("h_count", 32'(count), 32'd0);
    acc = '0;
    repeat (100) begin
      #1 acc = acc | cw;
      @(negedge clk);
    end
    check("h_quiet", 32'(acc), 32'd0);
    check("h_still", 32'(dut.state_q), 32'(ST_HALT));
    reset = 1'b0;
    #1 check("h_rst_halted", 32'(halted), 32'd0);
    check("h_rst_state", 32'(dut.state_q), 32'(ST_IDLE));

    // Counter wrap on 4-bit instance: 16 NOPs, 4 cycles each after IDLE
    reset_b = 1'b1; advance_b = 1'b1; opcode_b = OP_NOP;
    repeat (61) @(negedge clk);
    #1 check("wrap_at_max", 32'(count_b), 32'd15);
    repeat (3) @(negedge clk);
    #1 check("wrap_done", 32'(done_b), 32'd1);
    @(negedge clk);
    #1 check("wrap_zero", 32'(count_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
